// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-zero constant,
// ALU opcode encodings and the ID/EX stage occupancy states.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned IMM_W  = 16;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_AND = 3'b001,
      ALU_XOR = 3'b010,
      ALU_SUB = 3'b100,
      ALU_OR  = 3'b101,
      ALU_LUI = 3'b110
   } alu_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

endpackage

// File: rtl/id_ex_stage_op_fwd_mux.sv
// Operand bypass mux for one source register. Register zero always reads
// as zero; otherwise the instruction held in ID/EX (non-load) wins over
// the MEM-stage writer, which wins over the register file.
module op_fwd_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] operand
);

   logic ex_hit;
   logic mem_hit;

   // A held load has no result yet, so it is never a bypass source
   always_comb begin
      ex_hit  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_dst == addr);
      mem_hit = mem_we & (mem_dst == addr);
   end

   // Priority select: zero register, EX result, MEM result, register file
   always_comb begin
      operand = rf_data;
      if (addr == '0) begin
         operand = '0;
      end else if (ex_hit) begin
         operand = ex_data;
      end else if (mem_hit) begin
         operand = mem_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Resolves both operands through
// the bypass network, extends the immediate, detects load-use hazards and
// handles stall, bubble, drain and flush.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [IMM_W-1:0]  imm,
   input  logic              imm_sign,
   input  logic              use_imm,
   input  logic [2:0]        alu_op,
   input  logic [REG_AW-1:0] dst_addr,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] num1,
   output logic [DATA_W-1:0] num2,
   output logic [2:0]        operateType,
   output logic [REG_AW-1:0] out_dst,
   output logic              out_reg_write,
   output logic              out_mem_read
);

   import cpu_pkg::*;

   stage_state_e      state_q, state_d;
   logic [DATA_W-1:0] num1_q, num1_d;
   logic [DATA_W-1:0] num2_q, num2_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_read_q, mem_read_d;

   logic [DATA_W-1:0] rs_operand;
   logic [DATA_W-1:0] rt_operand;
   logic [DATA_W-1:0] imm_ext;
   logic              held_valid;
   logic              hazard;
   logic              stall;
   logic              capture;

   assign held_valid = (state_q == ST_FULL);

   op_fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_rs_fwd (
      .addr         (rs_addr),
      .rf_data      (rs_data),
      .ex_valid     (held_valid),
      .ex_reg_write (reg_write_q),
      .ex_mem_read  (mem_read_q),
      .ex_dst       (dst_q),
      .ex_data      (alu_result),
      .mem_we       (mem_we),
      .mem_dst      (mem_dst),
      .mem_data     (mem_data),
      .operand      (rs_operand)
   );

   op_fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_rt_fwd (
      .addr         (rt_addr),
      .rf_data      (rt_data),
      .ex_valid     (held_valid),
      .ex_reg_write (reg_write_q),
      .ex_mem_read  (mem_read_q),
      .ex_dst       (dst_q),
      .ex_data      (alu_result),
      .mem_we       (mem_we),
      .mem_dst      (mem_dst),
      .mem_data     (mem_data),
      .operand      (rt_operand)
   );

   // Immediate extension, load-use hazard detection and handshake
   always_comb begin
      imm_ext  = {{(DATA_W-IMM_W){imm_sign & imm[IMM_W-1]}}, imm};
      hazard   = held_valid & mem_read_q & reg_write_q & (dst_q != '0) & in_valid &
                 ((dst_q == rs_addr) | (~use_imm & (dst_q == rt_addr)));
      stall    = held_valid & ~out_ready;
      in_ready = (~held_valid | out_ready) & ~hazard & ~flush;
      capture  = in_valid & in_ready;
   end

   // Next-state: capture, hold on stall, otherwise empty with flags cleared.
   // Flush is checked before stall so it also kills a stalled instruction.
   always_comb begin
      state_d     = state_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      op_d        = op_q;
      dst_d       = dst_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end else if (stall) begin
         state_d = state_q;
      end else if (capture) begin
         state_d     = ST_FULL;
         num1_d      = rs_operand;
         num2_d      = use_imm ? imm_ext : rt_operand;
         op_d        = alu_op;
         dst_d       = dst_addr;
         reg_write_d = reg_write;
         mem_read_d  = mem_read;
      end else begin
         state_d     = ST_EMPTY;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end
   end

   // Pipeline register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         num1_q      <= '0;
         num2_q      <= '0;
         op_q        <= '0;
         dst_q       <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
         op_q        <= op_d;
         dst_q       <= dst_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   assign out_valid     = held_valid;
   assign num1          = num1_q;
   assign num2          = num2_q;
   assign operateType   = op_q;
   assign out_dst       = dst_q;
   assign out_reg_write = reg_write_q;
   assign out_mem_read  = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ALU-bound transfers are queued
// when an instruction is presented for acceptance and compared when the
// stage hands them to EX/MEM; handshake and hold behaviour checked inline.
module tb_id_ex_stage;

   import cpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs_addr, rt_addr, dst_addr, mem_dst, out_dst;
   logic [31:0] rs_data, rt_data, alu_result, mem_data, num1, num2;
   logic [15:0] imm;
   logic        imm_sign, use_imm, reg_write, mem_read, mem_we, flush, out_ready;
   logic [2:0]  alu_op, operateType;
   logic        out_valid, out_reg_write, out_mem_read;

   typedef struct {
      logic [31:0] n1;
      logic [31:0] n2;
      logic [2:0]  op;
      logic [4:0]  dst;
      logic        rw;
      logic        mr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   id_ex_stage #(
      .DATA_W (32),
      .REG_AW (5),
      .IMM_W  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .imm           (imm),
      .imm_sign      (imm_sign),
      .use_imm       (use_imm),
      .alu_op        (alu_op),
      .dst_addr      (dst_addr),
      .reg_write     (reg_write),
      .mem_read      (mem_read),
      .alu_result    (alu_result),
      .mem_we        (mem_we),
      .mem_dst       (mem_dst),
      .mem_data      (mem_data),
      .flush         (flush),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .num1          (num1),
      .num2          (num2),
      .operateType   (operateType),
      .out_dst       (out_dst),
      .out_reg_write (out_reg_write),
      .out_mem_read  (out_mem_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd,
                        input logic [15:0] im, input logic sgn, input logic ui,
                        input logic [2:0] op, input logic [4:0] dst,
                        input logic rw, input logic mr);
      in_valid  = 1'b1;
      rs_addr   = rs;
      rs_data   = rsd;
      rt_addr   = rt;
      rt_data   = rtd;
      imm       = im;
      imm_sign  = sgn;
      use_imm   = ui;
      alu_op    = op;
      dst_addr  = dst;
      reg_write = rw;
      mem_read  = mr;
   endtask

   task automatic expect_xfer(input logic [31:0] n1, input logic [31:0] n2,
                              input logic [2:0] op, input logic [4:0] dst,
                              input logic rw, input logic mr);
      exp_t e;
      e.n1 = n1; e.n2 = n2; e.op = op; e.dst = dst; e.rw = rw; e.mr = mr;
      sb.push_back(e);
   endtask

   // Transfer monitor: a handshake seen here completes on the next edge
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("xfer_num1", num1, e.n1);
            chk("xfer_num2", num2, e.n2);
            chk("xfer_op", {29'b0, operateType}, {29'b0, e.op});
            chk("xfer_dst", {27'b0, out_dst}, {27'b0, e.dst});
            chk("xfer_rw", {31'b0, out_reg_write}, {31'b0, e.rw});
            chk("xfer_mr", {31'b0, out_mem_read}, {31'b0, e.mr});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      mem_we = 1'b0; mem_dst = '0; mem_data = '0; alu_result = '0;
      drive(5'd1, 32'd5, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, ALU_SUB, 5'd4, 1'b1, 1'b0);

      // Reset with in_valid held high
      tick();
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_num1", num1, 32'd0);
      chk("rst_num2", num2, 32'd0);
      chk("rst_op", {29'b0, operateType}, 32'd0);
      chk("rst_rw", {31'b0, out_reg_write}, 32'd0);
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_valid2", {31'b0, out_valid}, 32'd0);

      // Basic register operands
      tick();
      drive(5'd1, 32'd5, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1, 1'b0);
      expect_xfer(32'd5, 32'd7, ALU_ADD, 5'd4, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("basic_valid", {31'b0, out_valid}, 32'd1);
      tick();
      @(negedge clk);
      chk("drain_valid", {31'b0, out_valid}, 32'd0);
      chk("drain_rw", {31'b0, out_reg_write}, 32'd0);

      // Immediate sign / zero extension, back to back
      tick();
      drive(5'd1, 32'd3, 5'd2, 32'd7, 16'hFFFE, 1'b1, 1'b1, ALU_SUB, 5'd10, 1'b1, 1'b0);
      expect_xfer(32'd3, 32'hFFFF_FFFE, ALU_SUB, 5'd10, 1'b1, 1'b0);
      tick();
      drive(5'd1, 32'd3, 5'd2, 32'd7, 16'hFFFE, 1'b0, 1'b1, ALU_OR, 5'd11, 1'b1, 1'b0);
      expect_xfer(32'd3, 32'h0000_FFFE, ALU_OR, 5'd11, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();

      // Bypass priority: EX over MEM over RF; register zero reads zero
      drive(5'd1, 32'd1, 5'd2, 32'd2, 16'h0, 1'b0, 1'b0, ALU_ADD, 5'd3, 1'b1, 1'b0);
      expect_xfer(32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0);
      tick();
      alu_result = 32'd9; mem_we = 1'b1; mem_dst = 5'd3; mem_data = 32'd4;
      drive(5'd3, 32'd1, 5'd5, 32'd6, 16'h0, 1'b0, 1'b0, ALU_XOR, 5'd6, 1'b1, 1'b0);
      expect_xfer(32'd9, 32'd6, ALU_XOR, 5'd6, 1'b1, 1'b0);
      tick();
      drive(5'd0, 32'd1, 5'd3, 32'd2, 16'h0, 1'b0, 1'b0, ALU_LUI, 5'd9, 1'b1, 1'b0);
      expect_xfer(32'd0, 32'd4, ALU_LUI, 5'd9, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0; mem_we = 1'b0; alu_result = '0;
      tick();

      // Load-use: one refused cycle, a bubble, then capture via MEM bypass
      drive(5'd1, 32'd10, 5'd0, 32'd0, 16'h0004, 1'b1, 1'b1, ALU_ADD, 5'd2, 1'b1, 1'b1);
      expect_xfer(32'd10, 32'd4, ALU_ADD, 5'd2, 1'b1, 1'b1);
      tick();
      drive(5'd2, 32'd99, 5'd5, 32'd8, 16'h0, 1'b0, 1'b0, ALU_ADD, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      mem_we = 1'b1; mem_dst = 5'd2; mem_data = 32'd42;
      expect_xfer(32'd42, 32'd8, ALU_ADD, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      chk("bubble_valid", {31'b0, out_valid}, 32'd0);
      chk("bubble_rw", {31'b0, out_reg_write}, 32'd0);
      chk("bubble_mr", {31'b0, out_mem_read}, 32'd0);
      chk("bubble_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; mem_we = 1'b0;
      tick();

      // Stall for three cycles: outputs stable, input refused
      drive(5'd1, 32'd11, 5'd2, 32'd22, 16'h0, 1'b0, 1'b0, ALU_AND, 5'd8, 1'b1, 1'b0);
      expect_xfer(32'd11, 32'd22, ALU_AND, 5'd8, 1'b1, 1'b0);
      tick();
      out_ready = 1'b0;
      drive(5'd3, 32'd33, 5'd4, 32'd44, 16'h0, 1'b0, 1'b0, ALU_SUB, 5'd12, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_num1", num1, 32'd11);
         chk("stall_num2", num2, 32'd22);
         chk("stall_op", {29'b0, operateType}, {29'b0, ALU_AND});
         tick();
      end
      out_ready = 1'b1;
      tick();
      // Second instruction now held; stall it, then flush it
      out_ready = 1'b0;
      drive(5'd5, 32'd55, 5'd6, 32'd66, 16'h0, 1'b0, 1'b0, ALU_OR, 5'd13, 1'b1, 1'b0);
      @(negedge clk);
      chk("held2_num1", num1, 32'd33);
      chk("held2_dst", {27'b0, out_dst}, 32'd12);
      tick();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_rw", {31'b0, out_reg_write}, 32'd0);
      chk("flush_num1", num1, 32'd33);

      // Reset while stalled discards the held instruction
      tick();
      drive(5'd1, 32'd77, 5'd2, 32'd88, 16'h0, 1'b0, 1'b0, ALU_ADD, 5'd14, 1'b1, 1'b0);
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_num1", num1, 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      tick();

      chk("sb_left", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
